// File: rtl/decode_queue.sv
// decode_queue: fetch-side instruction FIFO feeding a registered RV64I decoder
// with valid/ready handshakes on both sides and a synchronous flush.
module decode_queue #(
  parameter int DEPTH     = 4,
  parameter bit SUPPORT_W = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_pc,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic [63:0] out_imm,
  output logic [3:0]  out_alufunc,
  output logic        out_word,
  output logic        out_regwrite,
  output logic        out_selecta,
  output logic        out_selectb,
  output logic        out_branch,
  output logic        out_pcsrc,
  output logic        out_pctarget,
  output logic [2:0]  out_brcond,
  output logic [1:0]  out_wbselect,
  output logic [1:0]  out_memrw,
  output logic [1:0]  out_memsize,
  output logic        out_memunsigned,
  output logic        out_illegal
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // funct3 -> alufunc for the non-alternate encodings, nibble per funct3 value
  localparam logic [31:0] ALU_MAP = {4'd4, 4'd3, 4'd6, 4'd2, 4'd9, 4'd8, 4'd5, 4'd0};
  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic [3:0]  alufunc;
    logic        word;
    logic        regwrite;
    logic        selecta;
    logic        selectb;
    logic        branch;
    logic        pcsrc;
    logic        pctarget;
    logic [2:0]  brcond;
    logic [1:0]  wbselect;
    logic [1:0]  memrw;
    logic [1:0]  memsize;
    logic        memunsigned;
    logic        illegal;
  } ctrl_t;
  logic [95:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          empty, push, load, pop, bad, w_f3, bad_f7;
  logic [63:0]   hpc, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0]   i;
  logic [2:0]    f3;
  logic [6:0]    f7;
  logic [3:0]    alu_base, alu_imm, alu_reg;
  ctrl_t         d, q;
  assign empty    = count == '0;
  assign in_ready = count != CW'(DEPTH);
  assign push     = in_valid && in_ready && !flush;
  assign load     = !out_valid || out_ready;
  assign pop      = load && !empty;
  assign {hpc, i} = mem[rd_ptr];
  assign f3       = i[14:12];
  assign f7       = i[31:25];
  assign imm_i    = {{52{i[31]}}, i[31:20]};
  assign imm_s    = {{52{i[31]}}, i[31:25], i[11:7]};
  assign imm_b    = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  assign imm_u    = {{32{i[31]}}, i[31:12], 12'b0};
  assign imm_j    = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  assign alu_base = ALU_MAP[{f3, 2'b00} +: 4];
  assign alu_imm  = (f3 == 3'd5 && i[30]) ? 4'd7 : alu_base;
  assign alu_reg  = (f7 == 7'h20) ? (f3 == 3'd0 ? 4'd1 : 4'd7) : alu_base;
  assign bad_f7   = f7 != 7'h00 && !(f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
  assign w_f3     = f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5;
  always_comb begin
    d       = '0;
    bad     = 1'b0;
    d.pc    = hpc;
    d.rs1   = i[19:15];
    d.rs2   = i[24:20];
    d.rd    = i[11:7];
    case (i[6:0])
      7'h13: begin d.imm = imm_i; d.selectb = 1'b1; d.regwrite = 1'b1; d.alufunc = alu_imm; end
      7'h1b: begin
        d.imm = imm_i; d.selectb = 1'b1; d.regwrite = 1'b1; d.word = 1'b1; d.alufunc = alu_imm;
        bad = !SUPPORT_W || !w_f3;
      end
      7'h33: begin d.regwrite = 1'b1; d.alufunc = alu_reg; bad = bad_f7; end
      7'h3b: begin
        d.regwrite = 1'b1; d.word = 1'b1; d.alufunc = alu_reg;
        bad = !SUPPORT_W || !w_f3 || bad_f7;
      end
      7'h37: begin d.imm = imm_u; d.regwrite = 1'b1; d.wbselect = 2'b11; end
      7'h17: begin d.imm = imm_u; d.selecta = 1'b1; d.selectb = 1'b1; d.regwrite = 1'b1; end
      7'h6f: begin
        d.imm = imm_j; d.regwrite = 1'b1; d.pcsrc = 1'b1; d.pctarget = 1'b1; d.wbselect = 2'b10;
      end
      7'h67: begin
        d.imm = imm_i; d.regwrite = 1'b1; d.pcsrc = 1'b1; d.wbselect = 2'b10; d.selectb = 1'b1;
      end
      7'h63: begin
        d.imm = imm_b; d.branch = 1'b1; d.alufunc = 4'd1; d.brcond = f3;
        bad = f3[2:1] == 2'b01;
      end
      7'h03: begin
        d.imm = imm_i; d.selectb = 1'b1; d.regwrite = 1'b1; d.wbselect = 2'b01; d.memrw = 2'b01;
        d.memsize = f3[1:0]; d.memunsigned = f3[2];
        bad = f3 == 3'd7;
      end
      7'h23: begin
        d.imm = imm_s; d.selectb = 1'b1; d.memrw = 2'b10; d.memsize = f3[1:0];
        bad = f3[2];
      end
      default: bad = 1'b1;
    endcase
    // an illegal encoding must not cause any architectural side effect downstream
    d.regwrite = d.regwrite && !bad;
    d.branch   = d.branch && !bad;
    d.pcsrc    = d.pcsrc && !bad;
    d.memrw    = bad ? 2'b00 : d.memrw;
    d.illegal  = bad;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_pc, in_instr};
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      q         <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (load) out_valid <= !empty;
      if (pop) q <= d;
    end
  end
  assign {out_pc, out_rs1, out_rs2, out_rd, out_imm, out_alufunc, out_word, out_regwrite,
          out_selecta, out_selectb, out_branch, out_pcsrc, out_pctarget, out_brcond,
          out_wbselect, out_memrw, out_memsize, out_memunsigned, out_illegal} = q;
endmodule

// File: doc/decode_queue.md
# decode_queue

Decode stage with an instruction buffer. It sits between fetch and execute in the RV64 pipeline. It accepts `{pc, raw_instr}` from fetch through a valid/ready handshake and buffers them in a parametrised FIFO. It decodes the FIFO head into a registered control bundle, covering the full RV64I integer subset (optionally with the `*W` word ops), and flags illegal encodings. It presents the result to execute through a second valid/ready handshake. A flush drops all in-flight instructions.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `SUPPORT_W`, 1: when 1, decode OP-32/OP-IMM-32 (`addw`, `subw`, `addiw`, shifts-W); when 0, those encodings are illegal.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `resetn`, in, 1: asynchronous, active-low reset.
- `flush`, in, 1: synchronous discard of FIFO and output register.
- `in_valid`, in, 1: fetch offers an instruction.
- `in_ready`, out, 1: high when the FIFO is not full.
- `in_pc`, in, 64: PC of the offered instruction.
- `in_instr`, in, 32: raw instruction.
- `out_valid`, out, 1: output register holds a decoded instruction.
- `out_ready`, in, 1: execute accepts.
- `out_pc`, out, 64: PC of the decoded instruction.
- `out_rs1`, `out_rs2`, `out_rd`, out, 5 each: register indices, taken from instr[19:15], [24:20] and [11:7].
- `out_imm`, out, 64: sign-extended immediate (I/S/B/U/J format by opcode); 0 for R-type.
- `out_alufunc`, out, 4: ADD=0, SUB=1, XOR=2, OR=3, AND=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
- `out_word`, out, 1: 32-bit op; the result is sign-extended from bit 31.
- `out_regwrite`, `out_selecta`, `out_selectb`, `out_branch`, `out_pcsrc`, `out_pctarget`, out, 1 each.
- `out_brcond`, out, 3: funct3 of the branch (BEQ=0, BNE=1, BLT=4, BGE=5, BLTU=6, BGEU=7).
- `out_wbselect`, out, 2: 00 = ALU, 01 = memory, 10 = pc+4, 11 = imm.
- `out_memrw`, out, 2: 00 = none, 01 = read, 10 = write.
- `out_memsize`, out, 2: log2 of the byte count; funct3[1:0].
- `out_memunsigned`, out, 1: funct3[2] for loads.
- `out_illegal`, out, 1: encoding not supported. When set, every write-enable and `out_memrw` are forced to 0.

## Operation
- **FIFO**
  - Circular buffer of `DEPTH` entries with read and write pointers of `$clog2(DEPTH)` bits; pointers wrap naturally.
  - Occupancy count is `$clog2(DEPTH)+1` bits.
  - A push occurs when `in_valid && in_ready && !flush`.
  - A pop occurs when the FIFO is non-empty and the output register loads.
- **Output register load condition**: `!out_valid || out_ready`.
  - If the load condition holds and the FIFO is non-empty, the register captures the decode of the head and `out_valid` becomes 1.
  - If the load condition holds and the FIFO is empty, `out_valid` becomes 0.
  - Otherwise the register holds its contents.
- **Decoder** (combinational on the FIFO head):
  - OP-IMM: `selectb=1`, `regwrite=1`. funct3 selects the alufunc. For shifts, imm[5:0] is the shamt; instr[30] selects SRA.
  - OP: `regwrite=1`. funct7 0x20 selects SUB or SRA. Any other funct7 except 0x00 is illegal.
  - LUI: `regwrite=1`, `wbselect=11`.
  - AUIPC: `selecta=1`, `selectb=1`, ADD, `regwrite=1`.
  - JAL: `regwrite=1`, `pcsrc=1`, `pctarget=1`, `wbselect=10`.
  - JALR: `regwrite=1`, `pcsrc=1`, `wbselect=10`, `selectb=1`, ADD.
  - BRANCH: `branch=1`, SUB, `brcond=funct3`. funct3 2 and 3 are illegal.
  - LOAD: ADD, `selectb=1`, `regwrite=1`, `wbselect=01`, `memrw=01`. funct3 7 is illegal.
  - STORE: ADD, `selectb=1`, `memrw=10`. funct3 above 3 is illegal.
  - Any other opcode is illegal.
- **Flush**: the FIFO empties (pointers and count to 0) and `out_valid` goes to 0 on the next edge. A push or pop in the same cycle is ignored.

## Timing
- **Reset** (`resetn` low, takes effect immediately, asynchronously):
  - Pointers, count and `out_valid` go to 0.
  - All `out_*` data fields go to 0.
  - `in_ready` is 1 while `resetn` is low.
- **Latency**: an instruction pushed at edge t into an empty FIFO with an empty output register has `out_valid=1` after edge t+1. There is no bypass path.
- **Throughput**: one instruction per cycle in steady state when `out_ready=1`.
- **Full FIFO**: `in_ready=0`, even if a pop happens in the same cycle (no pass-through).
- **Empty FIFO with a simultaneous push and load**: the pushed entry is not visible until the next cycle.
- **Capacity**: with `out_ready=0`, a maximum of `DEPTH+1` instructions are held (FIFO plus output register).
- **Stability**: `out_*` fields are stable while `out_valid && !out_ready`.

## Test plan
- **Basic decode**: reset, then push `0x00500093` (`addi x1,x0,5`) with `out_ready=1` → two edges later `out_valid=1`, `rd=1`, `rs1=0`, `imm=5`, alufunc ADD, `selectb=1`, `regwrite=1`, `illegal=0`.
- **Stream of four**: push `0x402081b3` (`sub x3,x1,x2`), `0x00813283` (`ld x5,8(x2)`), `0xfe208ee3` (`beq x1,x2,-4`), `0x00000000` back-to-back → outputs in order:
  - SUB with `rd=3`;
  - `memrw=01`, `wbselect=01`, `memsize=3`, `imm=8`;
  - `branch=1`, `brcond=0`, `imm=0xFFFF_FFFF_FFFF_FFFC`;
  - `illegal=1` with `regwrite=0`.
- **Backpressure**: hold `out_ready=0` and push 6 instructions → `in_ready` drops after the 5th is accepted and the 6th is held off. Then release `out_ready` → all 5 emerge in order at one per cycle, and the 6th follows.
- **Flush with contents**: with 3 entries queued and `out_valid=1`, assert `flush` together with `in_valid` → next cycle `out_valid=0` and the FIFO is empty. The instruction pushed in the flush cycle never appears.
- **Reset mid-stream**: drop `resetn` asynchronously while `out_valid=1` → `out_valid=0` and `in_ready=1` immediately, without waiting for a clock edge.
- **`SUPPORT_W=0`**: push `0x0010009b` (`addiw x1,x0,1`) → `illegal=1`. With `SUPPORT_W=1` → `word=1`, ADD, `regwrite=1`.
